// File: rtl/sound_pkg.sv
// Shared definitions for the sound/LPC serial receive path.
package sound_pkg;

    // Clocks per serial bit for the two link rates.
    localparam int unsigned CLKS_PER_BIT_CC  = 48;
    localparam int unsigned CLKS_PER_BIT_LPC = 96;

    // Receiver FSM encoding (kept as plain constants for legacy compatibility).
    typedef logic [2:0] rx_state_t;

    localparam rx_state_t StIdle   = 3'd0;
    localparam rx_state_t StStart  = 3'd1;
    localparam rx_state_t StData   = 3'd2;
    localparam rx_state_t StStop   = 3'd3;
    localparam rx_state_t StBreak  = 3'd4;
    localparam rx_state_t StCommit = 3'd5;

endpackage

// File: rtl/sound_word_ram.sv
// Simple dual-port word buffer: one write port, one registered read port.
// A read and a write to the same address in the same cycle return the old data.
module sound_word_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    // Write port and registered read; nonblocking update gives read-before-write.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem[rd_addr_i];
    end

endmodule

// File: rtl/sound_rx_word_store.sv
// 8N1-style serial receiver that packs characters into words and stores them in
// an internal buffer read back by the decoder. Includes glitch-rejecting start
// detect, stop-bit framing check, full/overflow flags and a frame-synchronous clear.
module sound_rx_word_store
    import sound_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_CC,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ADDR_W         = 9
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_rst_i,
    input  logic                          rx_i,
    input  logic [ADDR_W-1:0]             rd_addr_i,
    output logic [8*BYTES_PER_WORD-1:0]   q_o,
    output logic [ADDR_W:0]               words_written_o,
    output logic                          byte_strobe_o,
    output logic                          frame_err_o,
    output logic                          rx_full_o,
    output logic                          overflow_o
);

    localparam int unsigned WordW = 8 * BYTES_PER_WORD;
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned Half  = CLKS_PER_BIT / 2;
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW  = $clog2(DATA_BITS);
    localparam int unsigned PackW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CntW-1:0]  HalfEnd  = CntW'(Half - 1);
    localparam logic [CntW-1:0]  BitEnd   = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);
    localparam logic [PackW-1:0] PackLast = PackW'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0]  DepthM1  = (ADDR_W + 1)'(Depth - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_t            state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [PackW-1:0]     pack_q, pack_d;
    logic [WordW-1:0]     partial_q, partial_d;
    logic [ADDR_W:0]      ww_q, ww_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;

    logic                 wr_en;
    logic [WordW-1:0]     char_word;
    logic                 byte_strobe;
    logic                 frame_err;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver FSM, word packer, counters and frame-synchronous clear.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        pack_d      = pack_q;
        partial_d   = partial_q;
        ww_d        = ww_q;
        full_d      = full_q;
        ovf_d       = ovf_q;
        wr_en       = 1'b0;
        byte_strobe = 1'b0;
        frame_err   = 1'b0;

        // Partial word with the current character dropped into its lane.
        char_word = partial_q;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (pack_q == PackW'(i)) begin
                char_word[i*8 +: 8] = 8'(shreg_q);
            end
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Line must stay low to the middle of the start bit.
                if (rx_s_q) begin
                    state_d = StIdle;
                end else if (cnt_q == HalfEnd) begin
                    state_d = StData;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitEnd) begin
                    shreg_d[bit_q] = rx_s_q;
                    cnt_d          = '0;
                    if (bit_q == LastBit) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == BitEnd) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StCommit;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // Hold off until the line returns high so a stuck-low line is one error.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            StCommit: begin
                byte_strobe = 1'b1;
                state_d     = StIdle;
                if (pack_q == PackLast) begin
                    pack_d    = '0;
                    partial_d = '0;
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en  = 1'b1;
                        ww_d   = ww_q + 1'b1;
                        full_d = (ww_q == DepthM1);
                    end
                end else begin
                    pack_d    = pack_q + 1'b1;
                    partial_d = char_word;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Clear overrides everything, including a coincident commit.
        if (frame_rst_i) begin
            state_d     = rx_s_q ? StIdle : StBreak;
            cnt_d       = '0;
            bit_d       = '0;
            pack_d      = '0;
            partial_d   = '0;
            ww_d        = '0;
            full_d      = 1'b0;
            ovf_d       = 1'b0;
            wr_en       = 1'b0;
            byte_strobe = 1'b0;
            frame_err   = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            pack_q    <= '0;
            partial_q <= '0;
            ww_q      <= '0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            pack_q    <= pack_d;
            partial_q <= partial_d;
            ww_q      <= ww_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    // Write address tracks the committed word count; writes stop while full.
    sound_word_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (WordW)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (ww_q[ADDR_W-1:0]),
        .wr_data_i (char_word),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (q_o)
    );

    assign words_written_o = ww_q;
    assign byte_strobe_o   = byte_strobe;
    assign frame_err_o     = frame_err;
    assign rx_full_o       = full_q;
    assign overflow_o      = ovf_q;

endmodule
